fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front-end between the instruction memory and the CPU's in-order pipeline. Owns the fetch PC, issues read requests to memory with waitrequest back-pressure, and tracks outstanding reads so a full queue is never overrun. Buffers returned instructions in a small in-order queue and presents them to the decode stage with a valid/ready handshake. Supports a single-cycle redirect (branch/jump) that flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4: queue entries; also the cap on outstanding reads plus queued entries (power of two, ≥2)
- RESET_PC, 16'h0000: fetch address after reset
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- o_mem_addr  output  16  instruction read address (always even)
- o_mem_rd  output  1  read request
- i_mem_waitrequest  input  1  memory stalls the request; o_mem_rd and o_mem_addr held while high
- i_mem_rddata  input  16  read data
- i_mem_rddata_valid  input  1  response strobe; responses return in request order
- o_inst  output  16  instruction at queue head
- o_inst_pc  output  16  address of o_inst
- o_inst_valid  output  1  head entry valid
- i_inst_ready  input  1  decode stage consumes head this cycle
- i_redirect  input  1  one-cycle pulse: flush and restart fetch
- i_redirect_addr  input  16  new fetch address; bit 0 forced to 0

## Operation
- Reset values: o_mem_rd=0, o_mem_addr=RESET_PC, o_inst=0, o_inst_pc=0, o_inst_valid=0; queue count, outstanding count and drop count 0; state FETCH.
- Credit rule: request issued only when outstanding + count < DEPTH, with outstanding and count taken from registered state (no same-cycle pop credit).
- Request accepted on o_mem_rd && !i_mem_waitrequest; then outstanding += 1, fetch PC += 2 (wraps 16'hFFFE to 16'h0000). Each accepted request pushes its address into a PC shadow FIFO so o_inst_pc is exact.
- Response: if drop count > 0, discard and decrement drop count; else push {data, pc} to queue tail. Outstanding decrements on every response.
- Pop on o_inst_valid && i_inst_ready. Simultaneous push and pop on a full queue is legal; count unchanged.
- States: FETCH (may issue), WAIT (o_mem_rd high under waitrequest; address and rd frozen), DRAIN (drop count > 0; new requests allowed but their responses follow the dropped ones). FETCH→WAIT on issue with waitrequest; WAIT→FETCH on accept; any→DRAIN on redirect with in-flight reads; DRAIN→FETCH when drop count reaches 0.
- Redirect: queue count cleared same edge; fetch PC <= i_redirect_addr & ~1; drop count <= outstanding + (accept this cycle) − (response this cycle). A request stalled in WAIT is not withdrawn; it completes and is counted as dropped. No pop happens in the redirect cycle. Redirect during DRAIN adds to the existing drop count.
- Counter widths $clog2(DEPTH+1); outstanding never exceeds DEPTH.

## Timing
- Reset release → o_mem_rd=1, o_mem_addr=RESET_PC on the first clk edge after reset deasserts.
- Response in cycle t → o_inst_valid in cycle t+1 (queue registered).
- Redirect in cycle t → o_inst_valid=0 in t+1; first request at new address in t+1 if credits allow.
- Sustained throughput 1 inst/cycle with zero-wait memory and ready held high.
- Reset asserted mid-operation clears everything immediately; in-flight memory responses after release must not occur (memory shares reset).

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when queue empty, drop count 0 and a response arrives, o_inst/o_inst_pc/o_inst_valid driven combinationally from the response in cycle t; entry written only if not popped that cycle.
- Undefined: all responses go through the queue; latency per Timing.

## Structure
- Package fetch_pkg: fetch_entry_t {inst[15:0], pc[15:0]}, fetch_state_e {FETCH, WAIT, DRAIN}, default DEPTH, RESET_PC.
- Sub-module fetch_fifo: circular buffer of fetch_entry_t with push, pop, flush, count, full/empty; instantiated twice (PC shadow, instruction queue).

## Test plan
- Reset release, zero-wait memory returning 16'h1000+addr, ready=1 → o_inst_pc 0,2,4,… one per cycle, o_inst matches.
- Ready=0 for 10 cycles → exactly DEPTH+0 entries buffered, o_mem_rd drops when outstanding+count=4; no lost or duplicated instruction on ready release.
- Waitrequest high 3 cycles on addr 6 → o_mem_addr stays 6, o_mem_rd stays 1, single accept, next addr 8.
- Memory latency 3, redirect to 16'h0041 with 2 reads in flight → both stale responses discarded, next o_inst_pc=16'h0040.
- Fetch PC at 16'hFFFE → next request address 16'h0000.
- Reset asserted with full queue and 2 outstanding → o_inst_valid=0, o_mem_rd=0 immediately; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front-end.
package fetch_pkg;

    localparam int          FETCH_DEPTH    = 4;
    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with synchronous flush.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: none internally; caller never pushes into a full buffer without a same-cycle pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: credited in-order memory reads, PC shadow, instruction queue, redirect flush (FETCH_QUEUE_BYPASS_EN: empty-queue bypass).
// Latency: response to o_inst_valid one cycle; zero cycles via bypass when the queue is empty.
// Backpressure: waitrequest freezes addr/rd; issue stops while outstanding + queued reaches DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic        i_mem_waitrequest,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_rddata_valid,
    output logic [15:0] o_inst,
    output logic [15:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_addr
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e  state, state_n;
    logic [15:0]   fetch_pc, fetch_pc_n;
    logic [15:0]   pend_pc, pend_pc_n;
    logic          pend_vld, pend_vld_n;
    logic          run;
    logic [CW-1:0] outstanding, out_n;
    logic [CW-1:0] drop_cnt, drop_n;
    logic [CW-1:0] q_cnt, pc_cnt;
    logic          q_full, q_empty, pc_full, pc_empty;
    logic          credit, accept, stall, resp, drop, bypass, q_push, q_pop;
    fetch_entry_t  pc_head, q_head, rsp_ent, pc_ent;
    logic          fifo_unused;

    assign credit     = ({1'b0, outstanding} + {1'b0, q_cnt}) < (CW+1)'(DEPTH);
    assign o_mem_rd   = run && (state == WAIT || credit);
    assign o_mem_addr = fetch_pc;
    assign accept     = o_mem_rd && !i_mem_waitrequest;
    assign stall      = o_mem_rd && i_mem_waitrequest;
    assign resp       = i_mem_rddata_valid;
    assign drop       = resp && (drop_cnt != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = resp && !drop && q_empty && !i_redirect;
`else
    assign bypass = 1'b0;
`endif

    assign o_inst_valid = !q_empty || bypass;
    assign q_pop        = !q_empty && i_inst_ready && !i_redirect;
    assign q_push       = resp && !drop && !i_redirect && !(bypass && i_inst_ready);
    assign rsp_ent      = '{inst: i_mem_rddata, pc: pc_head.pc};
    assign pc_ent       = '{inst: 16'h0000, pc: fetch_pc};

    always_comb begin
        o_inst    = '0;
        o_inst_pc = '0;
        if (!q_empty) begin
            o_inst    = q_head.inst;
            o_inst_pc = q_head.pc;
        end else if (bypass) begin
            o_inst    = i_mem_rddata;
            o_inst_pc = pc_head.pc;
        end
    end

    // A redirect that lands on a stalled request parks the target until that request is accepted.
    always_comb begin
        out_n      = outstanding;
        drop_n     = drop_cnt;
        fetch_pc_n = fetch_pc;
        pend_pc_n  = pend_pc;
        pend_vld_n = pend_vld;
        state_n    = FETCH;
        if (accept && !resp)      out_n = outstanding + 1'b1;
        else if (!accept && resp) out_n = outstanding - 1'b1;
        if (drop) drop_n = drop_cnt - 1'b1;
        if (accept) begin
            fetch_pc_n = pend_vld ? pend_pc : fetch_pc + 16'd2;
            pend_vld_n = 1'b0;
        end
        if (i_redirect) begin
            drop_n = out_n + CW'(stall && !pend_vld);
            if (stall) begin
                pend_vld_n = 1'b1;
                pend_pc_n  = i_redirect_addr & 16'hFFFE;
            end else begin
                pend_vld_n = 1'b0;
                fetch_pc_n = i_redirect_addr & 16'hFFFE;
            end
        end
        if (drop_n != '0) state_n = DRAIN;
        else if (stall)   state_n = WAIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            pend_pc     <= '0;
            pend_vld    <= 1'b0;
            run         <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pend_pc     <= pend_pc_n;
            pend_vld    <= pend_vld_n;
            run         <= 1'b1;
            outstanding <= out_n;
            drop_cnt    <= drop_n;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_pc_shadow (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (pc_ent),
        .pop      (resp),
        .flush    (1'b0),
        .head_dat (pc_head),
        .count    (pc_cnt),
        .full     (pc_full),
        .empty    (pc_empty)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_inst_q (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_dat (rsp_ent),
        .pop      (q_pop),
        .flush    (i_redirect),
        .head_dat (q_head),
        .count    (q_cnt),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign fifo_unused = ^{pc_head.inst, pc_cnt, pc_full, pc_empty, q_full};

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory model and a PC scoreboard.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        i_mem_waitrequest;
    logic [15:0] i_mem_rddata;
    logic        i_mem_rddata_valid;
    logic [15:0] o_inst;
    logic [15:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [15:0] i_redirect_addr;

    fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk                (clk),
        .reset              (reset),
        .o_mem_addr         (o_mem_addr),
        .o_mem_rd           (o_mem_rd),
        .i_mem_waitrequest  (i_mem_waitrequest),
        .i_mem_rddata       (i_mem_rddata),
        .i_mem_rddata_valid (i_mem_rddata_valid),
        .o_inst             (o_inst),
        .o_inst_pc          (o_inst_pc),
        .o_inst_valid       (o_inst_valid),
        .i_inst_ready       (i_inst_ready),
        .i_redirect         (i_redirect),
        .i_redirect_addr    (i_redirect_addr)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [15:0] sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          accepts  = 0;
    int          pops     = 0;
    int          acc6     = 0;
    logic [15:0] prev_acc = 16'h0000;
    logic        have_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_load(input logic [15:0] base, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(base + 16'(2 * i));
    endtask

    task automatic wait_pops(input int n, input int budget);
        int start;
        int k;
        start = pops;
        k = 0;
        while ((pops - start) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("pop_budget", 32'((pops - start) >= n), 32'd1);
    endtask

    // Memory responder and decode-side monitor; samples late in the cycle, drives just after the edge.
    initial begin
        req_t        r;
        logic [15:0] e;
        logic [15:0] e_inst;
        i_mem_rddata_valid = 1'b0;
        i_mem_rddata       = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i_mem_rddata_valid = 1'b0;
            i_mem_rddata       = 16'h0000;
            if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                i_mem_rddata_valid = 1'b1;
                i_mem_rddata       = 16'h1000 + r.addr;
            end
            @(negedge clk);
            #3;
            if (!reset) begin
                pend.delete();
                have_prev = 1'b0;
            end else begin
                if (o_mem_rd && !i_mem_waitrequest) begin
                    if (have_prev && prev_acc == 16'hFFFE) chk("wrap_addr", o_mem_addr, 16'h0000);
                    prev_acc  = o_mem_addr;
                    have_prev = 1'b1;
                    pend.push_back('{addr: o_mem_addr, due: cyc + lat});
                    accepts++;
                    if (o_mem_addr == 16'h0006) acc6++;
                end
                if (o_inst_valid && i_inst_ready && !i_redirect) begin
                    pops++;
                    if (sb.size() == 0) begin
                        chk("sb_underflow_pc", o_inst_pc, 16'hDEAD);
                    end else begin
                        e      = sb.pop_front();
                        e_inst = 16'h1000 + e;
                        chk("inst_pc", o_inst_pc, e);
                        chk("inst", o_inst, e_inst);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        reset             = 1'b0;
        i_mem_waitrequest = 1'b0;
        i_inst_ready      = 1'b0;
        i_redirect        = 1'b0;
        i_redirect_addr   = 16'h0000;
        repeat (3) @(negedge clk);

        chk("rst_mem_rd", o_mem_rd, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 16'h0000);
        chk("rst_inst", o_inst, 16'h0000);
        chk("rst_inst_pc", o_inst_pc, 16'h0000);
        chk("rst_inst_valid", o_inst_valid, 1'b0);

        // Streaming from reset with zero-wait memory.
        sb_load(16'h0000, 64);
        reset        = 1'b1;
        i_inst_ready = 1'b1;
        #1;
        chk("rd_before_edge", o_mem_rd, 1'b0);
        @(negedge clk);
        chk("first_rd", o_mem_rd, 1'b1);
        chk("first_addr", o_mem_addr, 16'h0000);
        wait_pops(1, 20);
        p0 = pops;
        repeat (16) @(negedge clk);
        chk("throughput", 32'(pops - p0), 32'd16);

        // Decode stalled: queue fills to DEPTH and issue stops.
        i_inst_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_rd", o_mem_rd, 1'b0);
        chk("stall_valid", o_inst_valid, 1'b1);
        chk("stall_buffered", 32'(accepts - pops), 32'd4);
        i_inst_ready = 1'b1;
        wait_pops(8, 50);

        // Waitrequest held for three cycles on address 6.
        i_redirect      = 1'b1;
        i_redirect_addr = 16'h0006;
        sb_load(16'h0006, 40);
        acc6 = 0;
        @(negedge clk);
        i_redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr_held", o_mem_addr, 16'h0006);
            chk("wr_rd_held", o_mem_rd, 1'b1);
            i_mem_waitrequest = (i < 3);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        chk("wr_next_addr", o_mem_addr, 16'h0008);
        chk("wr_single_accept", 32'(acc6), 32'd1);
        wait_pops(6, 60);

        // Latency-3 memory, redirect to an odd address with reads in flight.
        lat = 3;
        wait_pops(4, 60);
        i_redirect      = 1'b1;
        i_redirect_addr = 16'h0041;
        sb_load(16'h0040, 40);
        @(negedge clk);
        i_redirect = 1'b0;
        chk("redir_valid_low", o_inst_valid, 1'b0);
        chk("redir_addr", o_mem_addr, 16'h0040);
        wait_pops(6, 80);

        // Fetch PC wrap at the top of the address space.
        lat             = 1;
        i_redirect      = 1'b1;
        i_redirect_addr = 16'hFFFC;
        sb_load(16'hFFFC, 40);
        @(negedge clk);
        i_redirect = 1'b0;
        wait_pops(6, 60);

        // Reset asserted mid-operation with a loaded queue.
        lat          = 3;
        i_inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", o_inst_valid, 1'b0);
        chk("midrst_rd", o_mem_rd, 1'b0);
        sb_load(16'h0000, 40);
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        i_inst_ready = 1'b1;
        @(negedge clk);
        chk("resume_rd", o_mem_rd, 1'b1);
        chk("resume_addr", o_mem_addr, 16'h0000);
        wait_pops(8, 80);

        i_inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
